// File: rtl/count_pkg.sv
// Shared types and default sizing for the count_sched scheduler.
package count_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/count_core.sv
// Shared W-bit counter: loads start/end together, increments with wrap, flags terminal count.
module count_core #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic [W-1:0] i_start,
    input  logic [W-1:0] i_end,
    output logic [W-1:0] o_count,
    output logic         o_at_end
);

    logic [W-1:0] r_count;
    logic [W-1:0] r_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_end   <= '0;
        end else if (i_load) begin
            r_count <= i_start;
            r_end   <= i_end;
        end else if (i_inc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_end = (r_count == r_end);

endmodule

// File: rtl/count_sched.sv
// Round-robin owner of a shared counter: grant, load, count to terminal value, pulse done.
module count_sched
    import count_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] start_val,
    input  logic [NREQ*W-1:0] end_val,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_last, w_last_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_owner_req;
    logic            w_load;
    logic            w_inc;
    logic            w_at_end;
    logic [W-1:0]    w_start;
    logic [W-1:0]    w_end;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!w_any && req[(32'(r_last) + k) % NREQ]) begin
                w_any  = 1'b1;
                w_pick = IW'((32'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_owner_req = req[r_owner];
    assign w_start     = start_val[32'(r_owner)*W +: W];
    assign w_end       = end_val[32'(r_owner)*W +: W];

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_state_nxt = StLoad;
                end
            end
            StLoad, StRun: begin
                // Owner dropping its request abandons the run without a done pulse.
                if (!w_owner_req) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end else if (r_state == StLoad) begin
                    w_load      = 1'b1;
                    w_state_nxt = StRun;
                end else if (w_at_end) begin
                    w_done_nxt  = r_gnt;
                    w_state_nxt = StDone;
                end else begin
                    w_inc = 1'b1;
                end
            end
            StDone: begin
                w_gnt_nxt   = '0;
                w_last_nxt  = r_owner;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
            r_gnt   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    count_core #(
        .W(W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_inc   (w_inc),
        .i_start (w_start),
        .i_end   (w_end),
        .o_count (count),
        .o_at_end(w_at_end)
    );

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: directed vector table, corner sequences, random traffic vs schedule model.
module tb_count_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] start_val;
    logic [NREQ*W-1:0] end_val;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      count;

    count_sched #(
        .NREQ(NREQ),
        .W   (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .start_val(start_val),
        .end_val  (end_val),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: a run granted at cycle G loads at G, counts s..e over G+1..G+1+d, done at G+2+d.
    int              m_active;
    int              m_owner;
    int              m_last;
    int              m_g;
    int              m_cyc;
    int unsigned     m_s;
    int unsigned     m_d;
    logic [W-1:0]    m_count;
    logic [NREQ-1:0] m_gnt;
    logic [NREQ-1:0] m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, m_cyc, act, exp);
        end
    endtask

    task automatic model_abort();
        m_active = 0;
        m_last   = m_owner;
        m_gnt    = '0;
    endtask

    task automatic model_edge(input logic rs, input logic [NREQ-1:0] rq,
                              input logic [NREQ*W-1:0] sv, input logic [NREQ*W-1:0] ev);
        int age;
        int idx;
        int unsigned e;
        m_done = '0;
        m_cyc++;
        if (!rs) begin
            m_active = 0;
            m_last   = NREQ - 1;
            m_count  = '0;
            m_gnt    = '0;
        end else if (m_active == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (m_active == 0 && rq[idx]) begin
                    m_active   = 1;
                    m_owner    = idx;
                    m_g        = m_cyc;
                    m_gnt      = '0;
                    m_gnt[idx] = 1'b1;
                end
            end
        end else begin
            age = m_cyc - 1 - m_g;
            if (age == 0) begin
                if (!rq[m_owner]) model_abort();
                else begin
                    m_s     = 32'(sv[m_owner*W +: W]);
                    e       = 32'(ev[m_owner*W +: W]);
                    m_d     = (e - m_s) & ((32'd1 << W) - 1);
                    m_count = W'(m_s);
                end
            end else if (age <= 1 + int'(m_d)) begin
                if (!rq[m_owner]) model_abort();
                else begin
                    m_count = W'(m_s + ((age < int'(m_d)) ? age : m_d));
                    if (age == 1 + int'(m_d)) m_done = m_gnt;
                end
            end else begin
                model_abort();
            end
        end
    endtask

    task automatic tick();
        logic              rs;
        logic [NREQ-1:0]   rq;
        logic [NREQ*W-1:0] sv;
        logic [NREQ*W-1:0] ev;
        rs = rst;
        rq = req;
        sv = start_val;
        ev = end_val;
        @(posedge clk);
        model_edge(rs, rq, sv, ev);
        #1;
        check("model_gnt", 32'(gnt), 32'(m_gnt));
        check("model_busy", 32'(busy), 32'(m_active != 0));
        check("model_done", 32'(done), 32'(m_done));
        check("model_count", 32'(count), 32'(m_count));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [W-1:0]    s0;
        logic [W-1:0]    e0;
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [NREQ-1:0] done;
        logic [W-1:0]    count;
    } vec_t;

    vec_t tbl[8];
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] grants[$];
    logic [NREQ-1:0] rr_exp[5];
    logic [W-1:0]    wrap_exp[4];

    initial begin
        m_cyc    = 0;
        m_active = 0;
        m_last   = NREQ - 1;
        m_owner  = 0;
        m_g      = 0;
        m_s      = 0;
        m_d      = 0;
        m_count  = '0;
        m_gnt    = '0;
        m_done   = '0;
        rst       = 1'b0;
        req       = '0;
        start_val = '0;
        end_val   = '0;

        // Reset then idle with req low
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_count", 32'(count), 32'd0);
        end

        // Single run 5..8 on requester 0
        tbl[0] = '{4'b0001, 16'd5, 16'd8, 4'b0001, 1'b1, 4'b0000, 16'd0};
        tbl[1] = '{4'b0001, 16'd5, 16'd8, 4'b0001, 1'b1, 4'b0000, 16'd5};
        tbl[2] = '{4'b0001, 16'd5, 16'd8, 4'b0001, 1'b1, 4'b0000, 16'd6};
        tbl[3] = '{4'b0001, 16'd5, 16'd8, 4'b0001, 1'b1, 4'b0000, 16'd7};
        tbl[4] = '{4'b0001, 16'd9, 16'd9, 4'b0001, 1'b1, 4'b0000, 16'd8};
        tbl[5] = '{4'b0001, 16'd9, 16'd9, 4'b0001, 1'b1, 4'b0001, 16'd8};
        tbl[6] = '{4'b0000, 16'd0, 16'd0, 4'b0000, 1'b0, 4'b0000, 16'd8};
        tbl[7] = '{4'b0000, 16'd0, 16'd0, 4'b0000, 1'b0, 4'b0000, 16'd8};
        for (int i = 0; i < 8; i++) begin
            req       = tbl[i].req;
            start_val = {48'h0, tbl[i].s0};
            end_val   = {48'h0, tbl[i].e0};
            tick();
            check("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
            check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
            check("tbl_done", 32'(done), 32'(tbl[i].done));
            check("tbl_count", 32'(count), 32'(tbl[i].count));
        end

        // All requesting, zero-length runs: strict rotation from requester 0
        do_reset();
        req       = 4'b1111;
        start_val = '0;
        end_val   = '0;
        prev_gnt  = '0;
        grants.delete();
        for (int i = 0; i < 24; i++) begin
            tick();
            if (gnt != 0 && prev_gnt == 0) grants.push_back(gnt);
            prev_gnt = gnt;
        end
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_grant_cnt", 32'(grants.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) check("rr_order", 32'(grants[i]), 32'(rr_exp[i]));
        end
        drain();

        // Wrap through zero
        tick();
        req       = 4'b0001;
        start_val = {48'h0, 16'hFFFE};
        end_val   = {48'h0, 16'h0001};
        tick();
        check("wrap_gnt", 32'(gnt), 32'b0001);
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_count", 32'(count), 32'(wrap_exp[i]));
            check("wrap_nodone", 32'(done), 32'd0);
        end
        tick();
        check("wrap_done", 32'(done), 32'b0001);
        drain();

        // Abort by owner at count 3, requester 1 waiting
        do_reset();
        req       = 4'b0011;
        start_val = '0;
        end_val   = {4{16'd10}};
        for (int i = 0; i < 5; i++) tick();
        check("abort_pre_count", 32'(count), 32'd3);
        req = 4'b0010;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd3);
        tick();
        check("abort_next_gnt", 32'(gnt), 32'b0010);
        drain();

        // Reset mid-run, then pending requester 2 granted
        do_reset();
        req = 4'b0111;
        for (int i = 0; i < 4; i++) tick();
        check("rstrun_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        check("rstrun_gnt", 32'(gnt), 32'd0);
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_done", 32'(done), 32'd0);
        check("rstrun_count", 32'(count), 32'd0);
        rst = 1'b1;
        req = 4'b0100;
        tick();
        check("rstrun_regrant", 32'(gnt), 32'b0100);
        drain();

        // Random traffic against the schedule model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 7) == 0) begin
                    start_val[b*W +: W] = W'($urandom);
                    if ($urandom_range(0, 5) == 0) end_val[b*W +: W] = W'($urandom);
                    else end_val[b*W +: W] = start_val[b*W +: W] + W'($urandom_range(0, 8));
                end
            end
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
